// File: rtl/img_top_pkg.sv
// Shared pixel and window types for the image pipeline, plus small sizing helpers.
package img_top_pkg;

    typedef logic [7:0]         pixel_t;
    typedef pixel_t [0:7]       pix_bus_t;   // element 0 is the leftmost pixel
    typedef pixel_t [0:3]       pix_quad_t;
    typedef pixel_t [0:4][0:11] win5x12_t;   // [row][col], row 0 oldest line

    localparam int unsigned PIX_PER_BEAT = 8;
    localparam int unsigned NUM_LINES    = 4;

    typedef enum logic [0:0] {StFill, StStream} lb_state_e;

    // Counter width for values 0..range-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// One line of pixel beats: one write port, one registered read port, read-before-write.
module line_ram
    import img_top_pkg::*;
#(
    parameter int unsigned DEPTH  = 80,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  pix_bus_t          wdata,
    input  logic [ADDR_W-1:0] raddr,
    output pix_bus_t          rdata
);

    pix_bus_t mem [DEPTH];

    // Same-address read and write return the old contents.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/linebuffer5x12.sv
// Four-line buffer feeding a registered 5x12 window to the Gaussian core, two cycles after
// each accepted beat once four full lines of the current frame are held.
module linebuffer5x12
    import img_top_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    input  logic     in_sof,
    input  pix_bus_t in_pix,
    output logic     win_valid,
    output win5x12_t win
);

    localparam int unsigned BEATS_PER_LINE = IMG_WIDTH / PIX_PER_BEAT;
    localparam int unsigned COL_W = cnt_width(BEATS_PER_LINE);
    localparam int unsigned ROW_W = cnt_width(IMG_HEIGHT);
    localparam int unsigned LF_W  = cnt_width(NUM_LINES + 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(BEATS_PER_LINE - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [LF_W-1:0]  FULL      = LF_W'(NUM_LINES);

    logic [COL_W-1:0] col_q, col_d, col_eff;
    logic [ROW_W-1:0] row_q, row_d, row_eff;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [LF_W-1:0]  lines_q, lines_d, lines_eff;
    logic             sof;
    lb_state_e        state_q, state_d;
    logic             emit;

    assign sof       = in_valid & in_sof;
    assign col_eff   = sof ? '0 : col_q;
    assign row_eff   = sof ? '0 : row_q;
    assign lines_eff = sof ? '0 : lines_q;

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        wr_ptr_d = wr_ptr_q;
        lines_d  = lines_q;
        if (in_valid) begin
            col_d   = col_eff + COL_W'(1);
            row_d   = row_eff;
            lines_d = lines_eff;
            if (col_eff == LAST_COL) begin
                col_d    = '0;
                wr_ptr_d = wr_ptr_q + 2'd1;
                if (row_eff == LAST_ROW) begin
                    row_d   = '0;
                    lines_d = '0;
                end else begin
                    row_d = row_eff + ROW_W'(1);
                    if (lines_eff != FULL) begin
                        lines_d = lines_eff + LF_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            wr_ptr_q <= '0;
            lines_q  <= '0;
            state_q  <= StFill;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            wr_ptr_q <= wr_ptr_d;
            lines_q  <= lines_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            state_d = (lines_d == FULL) ? StStream : StFill;
        end
    end

    // A start-of-frame beat always belongs to a fresh fill, whatever the current state.
    always_comb begin
        emit = 1'b0;
        unique case (state_q)
            StFill:   emit = 1'b0;
            StStream: emit = in_valid & ~in_sof;
            default:  emit = 1'b0;
        endcase
    end

    pix_bus_t rd_data [NUM_LINES];

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        line_ram #(
            .DEPTH  (BEATS_PER_LINE),
            .ADDR_W (COL_W)
        ) u_line_ram (
            .clk   (clk),
            .we    (in_valid && (wr_ptr_q == 2'(i))),
            .waddr (col_eff),
            .wdata (in_pix),
            .raddr (col_eff),
            .rdata (rd_data[i])
        );
    end

    logic      s1_acc, s1_emit, s1_edge;
    logic [1:0] s1_ptr;
    pix_bus_t  s1_pix;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_acc  <= 1'b0;
            s1_emit <= 1'b0;
        end else begin
            s1_acc  <= in_valid;
            s1_emit <= emit;
        end
        s1_edge <= (col_eff == '0);
        s1_ptr  <= wr_ptr_q;
        s1_pix  <= in_pix;
    end

    pix_bus_t  rows [5];
    pix_quad_t prev_q [5];
    win5x12_t  win_d;

    // The memory about to be overwritten holds the oldest line.
    always_comb begin
        for (int k = 0; k < NUM_LINES; k++) begin
            rows[k] = rd_data[s1_ptr + 2'(k)];
        end
        rows[4] = s1_pix;
        win_d = '0;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                win_d[k][j] = s1_edge ? rows[k][0] : prev_q[k][j];
            end
            for (int j = 0; j < 8; j++) begin
                win_d[k][4+j] = rows[k][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win       <= '0;
            for (int k = 0; k < 5; k++) begin
                prev_q[k] <= '0;
            end
        end else begin
            win_valid <= s1_emit;
            if (s1_emit) begin
                win <= win_d;
            end
            if (s1_acc) begin
                for (int k = 0; k < 5; k++) begin
                    prev_q[k] <= rows[k][4:7];
                end
            end
        end
    end

endmodule
